// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//   Shared constants for the sync_fifo read-side stream adapter.
//   DATA_W_DEFAULT : default data width (matches sync_fifo)
//   FIFO_RD_LAT    : sync_fifo read latency in cycles (fifo_dout valid the
//                    cycle after fifo_rd_en)
//   BUF_DEPTH      : output buffer entries; one more than the steady-state
//                    occupancy needed to cover the read latency and the
//                    registered credit check
//   PTR_W          : buffer pointer / occupancy width
//   ptr_inc()      : circular pointer increment, wraps BUF_DEPTH-1 -> 0
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int DATA_W_DEFAULT = 8;
  localparam int FIFO_RD_LAT    = 1;
  localparam int BUF_DEPTH      = 3;
  localparam int PTR_W          = 2;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// ---------------------------------------------------------------------------
// fifo_rd_skid
//   3-entry circular output buffer for fifo_rd_stream. Words pushed at the
//   tail, head presented combinationally, popped by the consumer handshake.
//   Simultaneous push and pop keeps occupancy unchanged and preserves order.
// Ports
//   clk        in   clock, posedge
//   reset      in   asynchronous active-low reset (clears pointers/occupancy)
//   push       in   write push_data at the tail this edge
//   push_data  in   DW-bit word to store
//   pop        in   advance the head this edge (ignored when empty)
//   occ        out  current occupancy, 0..BUF_DEPTH
//   head_data  out  word at the head; 0 when the buffer is empty
// ---------------------------------------------------------------------------
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int DW = DATA_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [DW-1:0]    push_data,
  input  logic             pop,
  output logic [PTR_W-1:0] occ,
  output logic [DW-1:0]    head_data
);

  logic [DW-1:0]    mem_reg [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] occ_reg;
  logic [PTR_W-1:0] occ_next;
  logic             pop_ok;

  assign pop_ok = pop && (occ_reg != '0);

  always_comb begin
    occ_next = occ_reg;
    case ({push, pop_ok})
      2'b10:   occ_next = occ_reg + 1'b1;
      2'b01:   occ_next = occ_reg - 1'b1;
      default: occ_next = occ_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (push)   wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop_ok) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      occ_reg <= occ_next;
    end
  end

  // Data storage carries no reset; the empty case is masked at the output.
  always_ff @(posedge clk) begin
    if (push) mem_reg[wr_ptr_reg] <= push_data;
  end

  assign occ       = occ_reg;
  assign head_data = (occ_reg != '0) ? mem_reg[rd_ptr_reg] : '0;

endmodule

// File: rtl/fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// fifo_rd_stream
//   Read-side master for sync_fifo. Pops words from the FIFO and presents
//   them on a valid/ready stream. The FIFO read latency is absorbed by a
//   3-entry buffer; reads are issued on credit (buffered + in-flight < 3), so
//   fifo_rd_en never depends on m_ready combinationally.
// Ports
//   clk         in   clock, posedge
//   reset       in   asynchronous active-low reset
//   fifo_empty  in   sync_fifo empty flag
//   fifo_dout   in   sync_fifo read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  out  pop request to sync_fifo
//   m_valid     out  stream word available
//   m_data      out  stream data (buffer head)
//   m_ready     in   consumer accepts when m_valid && m_ready
//   rd_count    out  delivered-word counter (only with FIFO_RD_CNT_EN)
// Configuration
//   FIFO_RD_CNT_EN : when defined, adds parameter CNT_W and the wrapping
//                    rd_count output incremented on every pop.
// ---------------------------------------------------------------------------
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
`ifdef FIFO_RD_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready
`ifdef FIFO_RD_CNT_EN
  , output logic [CNT_W-1:0] rd_count
`endif
);

  logic [FIFO_RD_LAT-1:0] inflight_reg;
  logic [PTR_W-1:0]       occ;
  logic [2:0]             pending;
  logic                   pop;

  // Words already committed to the buffer: held plus still in the FIFO's
  // read pipeline. Issue only while this leaves room for the new word.
  assign pending    = {1'b0, occ} + {2'b00, inflight_reg[0]};
  assign fifo_rd_en = reset && !fifo_empty && (pending < 3'(BUF_DEPTH));

  assign m_valid = (occ != '0);
  assign pop     = m_valid && m_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) inflight_reg <= '0;
    else        inflight_reg <= FIFO_RD_LAT'(fifo_rd_en);
  end

  fifo_rd_skid #(
    .DW (DATA_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight_reg[0]),
    .push_data (fifo_dout),
    .pop       (pop),
    .occ       (occ),
    .head_data (m_data)
  );

`ifdef FIFO_RD_CNT_EN
  logic [CNT_W-1:0] rd_count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   rd_count_reg <= '0;
    else if (pop) rd_count_reg <= rd_count_reg + 1'b1;
  end

  assign rd_count = rd_count_reg;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_stream
//   Bench for fifo_rd_stream with a behavioural sync_fifo (1-cycle read
//   latency) feeding it. Cycle table for latency/backpressure handshakes,
//   scoreboard for ordering, hand-written sequences for bursts and reset.
// ---------------------------------------------------------------------------
module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_rd_en;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready = 1'b0;
`ifdef FIFO_RD_CNT_EN
  logic [3:0] rd_count;
`endif

  always #5 clk = ~clk;

`ifdef FIFO_RD_CNT_EN
  fifo_rd_stream #(.DATA_W(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_data(m_data),
    .m_ready(m_ready), .rd_count(rd_count));
`else
  fifo_rd_stream #(.DATA_W(8)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_data(m_data),
    .m_ready(m_ready));
`endif

  // Behavioural sync_fifo: write lands on the edge, read data registered.
  logic       wr_req = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] fmem [256];
  logic [7:0] fwp, frp;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      fwp       <= 8'd0;
      frp       <= 8'd0;
      fifo_dout <= 8'h00;
    end else begin
      if (wr_req) begin
        fmem[fwp] <= wr_data;
        fwp       <= fwp + 8'd1;
      end
      if (fifo_rd_en) begin
        fifo_dout <= fmem[frp];
        frp       <= frp + 8'd1;
      end
    end
  end
  assign fifo_empty = (fwp == frp);

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int delivered = 0;
  logic [7:0] expq [$];
  logic track = 1'b0;
  int first_pop = -1;
  int last_pop = -1;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Handshake monitor: ordering, no duplicates, no underflow reads.
  always @(negedge clk) begin
    if (reset) begin
      if (fifo_rd_en && fifo_empty) begin
        tests++;
        fails++;
        $display("FAIL underflow: fifo_rd_en=1 with fifo_empty=1 (cycle %0d)", cyc);
      end
      if (m_valid && m_ready) begin
        tests++;
        if (expq.size() == 0) begin
          fails++;
          $display("FAIL sb_extra: got %0h, expected no word (cycle %0d)", m_data, cyc);
        end else begin
          logic [7:0] e;
          e = expq.pop_front();
          if (m_data !== e) begin
            fails++;
            $display("FAIL sb_order: got %0h, expected %0h (cycle %0d)", m_data, e, cyc);
          end
        end
        delivered++;
        if (track) begin
          if (first_pop < 0) first_pop = cyc;
          last_pop = cyc;
        end
      end
    end
  end

  // Caller is at posedge+1; leaves wr_req low at posedge+1 of the final edge.
  task automatic burst(input int n, input logic [7:0] first, input int dir);
    for (int i = 0; i < n; i++) begin
      wr_req  = 1'b1;
      wr_data = 8'(int'(first) + dir * i);
      expq.push_back(wr_data);
      @(posedge clk); #1;
    end
    wr_req = 1'b0;
  endtask

  task automatic wait_delivered(input string name, input int target, input int budget);
    int k;
    k = 0;
    while (delivered < target && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, delivered, target);
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] wdata;
    logic       ready;
    logic       exp_rd_en;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vt [12];

  initial begin
    int base;
    // Single word latency, then two words held back one cycle.
    vt[0]  = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h00};
    vt[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    vt[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    vt[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h5A};
    vt[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    vt[5]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[6]  = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b0, 8'h00};
    vt[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    vt[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA1};
    vt[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA1};
    vt[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA2};
    vt[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};

    // Reset state
    #2;
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    #20 reset = 1'b1;

    // Cycle table
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      wr_req  = vt[i].wr;
      wr_data = vt[i].wdata;
      m_ready = vt[i].ready;
      if (vt[i].wr) expq.push_back(vt[i].wdata);
      @(negedge clk);
      check($sformatf("vec%0d_rd_en", i), fifo_rd_en, vt[i].exp_rd_en);
      check($sformatf("vec%0d_valid", i), m_valid, vt[i].exp_valid);
      check($sformatf("vec%0d_data", i), m_data, vt[i].exp_data);
    end
    @(posedge clk); #1;
    wr_req = 1'b0;

    // Stream 0xFF..0xF0 at full rate
    m_ready = 1'b1;
    base = delivered;
    track = 1'b1;
    first_pop = -1;
    burst(16, 8'hFF, -1);
    wait_delivered("stream_count", base + 16, 20);
    track = 1'b0;
    check("stream_rate", last_pop - first_pop, 15);
    check("stream_drained", expq.size(), 0);

    // Backpressure: 8 queued, consumer stalled
    m_ready = 1'b0;
    base = delivered;
    burst(8, 8'hE0, 1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("bp_rd_en", fifo_rd_en, 0);
    check("bp_valid", m_valid, 1);
    check("bp_head", m_data, 8'hE0);
    check("bp_fifo_left", 32'(fwp - frp), 5);
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_delivered("bp_count", base + 8, 30);
    check("bp_drained", expq.size(), 0);

    // Empty edge with toggling ready
    base = delivered;
    for (int i = 0; i < 25; i++) begin
      m_ready = i[0];
      if (i < 5) begin
        wr_req  = 1'b1;
        wr_data = 8'hC0 + 8'(i);
        expq.push_back(wr_data);
      end else begin
        wr_req = 1'b0;
      end
      @(posedge clk); #1;
    end
    check("toggle_count", delivered, base + 5);
    check("toggle_drained", expq.size(), 0);

    // Async reset mid-burst with two words buffered
    m_ready = 1'b0;
    burst(2, 8'h31, 1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("pre_rst_valid", m_valid, 1);
    check("pre_rst_data", m_data, 8'h31);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("t1_valid", m_valid, 0);
    check("t1_data", m_data, 0);
    check("t1_rd_en", fifo_rd_en, 0);
`ifdef FIFO_RD_CNT_EN
    check("t1_rd_count", rd_count, 0);
`endif
    expq.delete();
    @(negedge clk);
    reset = 1'b1;

`ifdef FIFO_RD_CNT_EN
    // Counter wrap with CNT_W=4: 17 pops end 15 -> 0 -> 1
    @(posedge clk); #1;
    m_ready = 1'b1;
    base = delivered;
    for (int i = 1; i <= 17; i++) begin
      int k;
      burst(1, 8'(8'h80 + i), 1);
      k = 0;
      while (delivered < base + i && k < 10) begin
        @(posedge clk); #1;
        k++;
      end
      if (i >= 15) check($sformatf("cnt_pop%0d", i), rd_count, 32'(i % 16));
    end
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
